// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: loads a 1..WIDTH bit pattern on START and shifts it out
// MSB-first on E, one bit per clock, with optional gap-free repeat of the captured pattern.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA,
    input  logic [LW-1:0]    LEN,
    input  logic             REPEAT,
    output logic             E,
    output logic             VALID,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [LW-1:0]    cnt, cnt_n;
    logic [LW-1:0]    hlen, hlen_n;
    logic             e_n, valid_n, busy_n, done_n;
    logic             len_ok;
    logic [WIDTH-1:0] aligned;

    always_comb begin
        len_ok  = (LEN >= ONE_L) && (LEN <= WIDTH_L);
        // Left-align so the first bit to send always sits in the MSB.
        aligned = DATA << (WIDTH_L - LEN);

        state_n = state;
        sreg_n  = sreg;
        hold_n  = hold;
        cnt_n   = cnt;
        hlen_n  = hlen;
        e_n     = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (START && len_ok) begin
                    sreg_n  = aligned;
                    hold_n  = aligned;
                    cnt_n   = LEN;
                    hlen_n  = LEN;
                    state_n = SHIFT;
                    e_n     = aligned[WIDTH-1];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt > ONE_L) begin
                    sreg_n  = sreg << 1;
                    cnt_n   = cnt - ONE_L;
                    e_n     = sreg_n[WIDTH-1];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else if (REPEAT) begin
                    // Reload from the captured copy so live DATA never leaks into a repeat.
                    sreg_n  = hold;
                    cnt_n   = hlen;
                    e_n     = hold[WIDTH-1];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    sreg_n  = '0;
                    cnt_n   = '0;
                    state_n = FIN;
                    done_n  = 1'b1;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered next-state values, so nothing combinational reaches a port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            sreg  <= '0;
            hold  <= '0;
            cnt   <= '0;
            hlen  <= '0;
            E     <= 1'b0;
            VALID <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            hold  <= hold_n;
            cnt   <= cnt_n;
            hlen  <= hlen_n;
            E     <= e_n;
            VALID <= valid_n;
            BUSY  <= busy_n;
            DONE  <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Table-driven bench for serial_pattern_gen: each record is one clock of inputs and the
// outputs expected in the cycle after that edge.
module tb_serial_pattern_gen;

    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [LW-1:0]    len;
    logic             rep;
    logic             e, valid, busy, done;

    int total;
    int bad;

    typedef struct {
        logic             rst;
        logic             start;
        logic [WIDTH-1:0] data;
        logic [LW-1:0]    len;
        logic             rep;
        logic [3:0]       exp;  // {E, VALID, BUSY, DONE}
    } vec_t;

    vec_t vecs[$];

    serial_pattern_gen #(.WIDTH(WIDTH), .LW(LW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .START (start),
        .DATA  (data),
        .LEN   (len),
        .REPEAT(rep),
        .E     (e),
        .VALID (valid),
        .BUSY  (busy),
        .DONE  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic s, input logic [WIDTH-1:0] d,
                                input logic [LW-1:0] l, input logic p, input logic [3:0] x);
        vec_t v;
        v.rst = r; v.start = s; v.data = d; v.len = l; v.rep = p; v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic r, input logic s, input logic [WIDTH-1:0] d,
                        input logic [LW-1:0] l, input logic p);
        rst = r; start = s; data = d; len = l; rep = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        total++;
        if ({e, valid, busy, done} !== exp) begin
            bad++;
            $display("FAIL %s: got {E,VALID,BUSY,DONE}=%b, expected %b", name, {e, valid, busy, done}, exp);
        end
    endtask

    // Output shorthands: bit 1 sent, bit 0 sent, DONE pulse, all quiet.
    localparam logic [3:0] B1 = 4'b1110;
    localparam logic [3:0] B0 = 4'b0110;
    localparam logic [3:0] DN = 4'b0001;
    localparam logic [3:0] Z  = 4'b0000;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; data = '0; len = '0; rep = 1'b0;

        // Reset held with START active, then a START in the release cycle.
        add(1, 1, 8'h06, 3, 0, Z);
        add(1, 1, 8'h06, 3, 0, Z);
        add(0, 1, 8'h06, 3, 0, B1);
        add(0, 0, 8'h06, 3, 0, B1);
        add(0, 0, 8'h06, 3, 0, B0);
        add(0, 0, 8'h06, 3, 0, DN);
        add(0, 0, 8'h00, 3, 0, Z);
        // Full width 0xA5.
        add(0, 1, 8'hA5, 8, 0, B1);
        add(0, 0, 8'hA5, 8, 0, B0);
        add(0, 0, 8'hA5, 8, 0, B1);
        add(0, 0, 8'hA5, 8, 0, B0);
        add(0, 0, 8'hA5, 8, 0, B0);
        add(0, 0, 8'hA5, 8, 0, B1);
        add(0, 0, 8'hA5, 8, 0, B0);
        add(0, 0, 8'hA5, 8, 0, B1);
        add(0, 0, 8'hA5, 8, 0, DN);
        add(0, 0, 8'hA5, 8, 0, Z);
        // Illegal lengths are rejected.
        add(0, 1, 8'hFF, 0, 0, Z);
        add(0, 1, 8'hFF, 9, 0, Z);
        add(0, 0, 8'hFF, 9, 0, Z);
        // Single-bit patterns.
        add(0, 1, 8'h01, 1, 0, B1);
        add(0, 0, 8'h01, 1, 0, DN);
        add(0, 0, 8'h01, 1, 0, Z);
        add(0, 1, 8'hFE, 1, 0, B0);
        add(0, 0, 8'hFE, 1, 0, DN);
        add(0, 0, 8'hFE, 1, 0, Z);
        // START with new DATA during SHIFT and FIN is ignored.
        add(0, 1, 8'h06, 3, 0, B1);
        add(0, 1, 8'hFF, 8, 0, B1);
        add(0, 1, 8'h00, 8, 0, B0);
        add(0, 1, 8'hFF, 8, 0, DN);
        add(0, 1, 8'hFF, 8, 0, Z);
        add(0, 0, 8'hFF, 8, 0, Z);
        // Repeat: REPEAT low mid-pattern does not matter, only at the last-bit edge.
        add(0, 1, 8'h06, 3, 1, B1);
        add(0, 0, 8'h06, 3, 1, B1);
        add(0, 0, 8'h06, 3, 1, B0);
        add(0, 0, 8'h06, 3, 1, B1);
        add(0, 1, 8'h00, 5, 0, B1);
        add(0, 0, 8'h00, 5, 0, B0);
        add(0, 0, 8'h00, 5, 1, B1);
        add(0, 0, 8'h00, 5, 0, B1);
        add(0, 0, 8'h00, 5, 0, B0);
        add(0, 0, 8'h00, 5, 0, DN);
        add(0, 0, 8'h00, 5, 0, Z);
        // Reset during the second bit of a LEN=5 pattern, then a fresh send.
        add(0, 1, 8'h16, 5, 0, B1);
        add(0, 0, 8'h16, 5, 0, B0);
        add(1, 0, 8'h16, 5, 0, Z);
        add(0, 0, 8'h16, 5, 0, Z);
        add(0, 1, 8'h16, 5, 0, B1);
        add(0, 0, 8'h16, 5, 0, B0);
        add(0, 0, 8'h16, 5, 0, B1);
        add(0, 0, 8'h16, 5, 0, B1);
        add(0, 0, 8'h16, 5, 0, B0);
        add(0, 0, 8'h16, 5, 0, DN);
        add(0, 0, 8'h16, 5, 0, Z);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].data, vecs[i].len, vecs[i].rep);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // LEN=1 with REPEAT: VALID must stay high with no gaps, then finish once REPEAT drops.
        step(0, 1, 8'h01, 1, 1);
        check("rep1_first", B1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 8'h00, 1, 1);
            check($sformatf("rep1_loop%0d", k), B1);
        end
        step(0, 0, 8'h00, 1, 0);
        check("rep1_done", DN);
        step(0, 0, 8'h00, 1, 0);
        check("rep1_idle", Z);

        // LEN=2 repeat of pattern 10: period of exactly two cycles.
        step(0, 1, 8'h02, 2, 1);
        check("rep2_b0", B1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'h03, 2, 1);
            check($sformatf("rep2_lo%0d", k), B0);
            step(0, 0, 8'h03, 2, 1);
            check($sformatf("rep2_hi%0d", k), B1);
        end
        step(0, 0, 8'h03, 2, 0);
        check("rep2_last", B0);
        step(0, 0, 8'h03, 2, 0);
        check("rep2_done", DN);
        step(0, 0, 8'h03, 2, 0);
        check("rep2_idle", Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial bit-stream transmitter that produces the single-bit input `E` consumed by the `mealy_fsm` sequence detector. A parallel pattern of 1..`WIDTH` bits is loaded on a start request and shifted out MSB-first, one bit per clock, with registered outputs so `E` is stable for a whole cycle. An optional repeat mode re-sends the same pattern back-to-back without gaps. It replaces hand-written stimulus sequences in detector benches and top-level demos.

## Interface
- `WIDTH`, 8: maximum pattern length in bits, ≥2.
- `LW`, `$clog2(WIDTH+1)`: width of the length field.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `START`  in  1  request to send; sampled only in IDLE.
- `DATA`  in  `WIDTH`  pattern; bits `DATA[LEN-1]` down to `DATA[0]` are sent, in that order.
- `LEN`  in  `LW`  number of bits to send, 1..`WIDTH`. Values 0 or >`WIDTH` reject START.
- `REPEAT`  in  1  when high at the edge that ends the last bit, the pattern restarts immediately.
- `E`  out  1  serial data bit, registered.
- `VALID`  out  1  high while `E` carries a pattern bit.
- `BUSY`  out  1  high in SHIFT.
- `DONE`  out  1  one-cycle pulse after the final bit of a non-repeated transmission.

## Operation
- States: IDLE, SHIFT, FIN. Reset state IDLE.
- Reset values: `E`=0, `VALID`=0, `BUSY`=0, `DONE`=0, shift register and counter 0.
- IDLE: outputs all 0. At an edge with `START`=1 and 1≤`LEN`≤`WIDTH`: capture `DATA` left-aligned (`DATA << (WIDTH-LEN)`) into shift register and into a hold register, capture `LEN` into counter and length-hold register, go to SHIFT. Otherwise stay in IDLE.
- SHIFT: `E` = shift register MSB, `VALID`=1, `BUSY`=1. Each edge: if counter > 1, shift left by one (zero fill), decrement counter. If counter = 1 (last bit): with `REPEAT`=1, reload from hold registers and stay in SHIFT; with `REPEAT`=0, go to FIN.
- FIN: `DONE`=1, `E`=0, `VALID`=0, `BUSY`=0 for exactly one cycle, then IDLE. `START` is ignored in FIN.
- `START`, `DATA`, `LEN` changes during SHIFT/FIN have no effect; repeat always resends the captured pattern, never live `DATA`.
- `REPEAT` is only sampled at the last-bit edge; dropping it mid-pattern finishes the current pattern normally.
- RESET has priority over everything in every state; mid-transmission it aborts to IDLE with all outputs 0 on the next cycle, no `DONE` pulse.

## Timing
- Start latency: `START` sampled at edge k → first bit on `E` during cycle k+1 (after edge k).
- Bit i (0-based) of a pattern appears in cycle k+1+i; pattern occupies exactly `LEN` cycles.
- Non-repeat: `DONE` high in cycle k+1+`LEN`; earliest next accepted `START` at edge ending that IDLE cycle, i.e. next first bit in cycle k+3+`LEN`.
- Repeat: zero idle cycles between patterns; period exactly `LEN` cycles; `VALID` stays high continuously.
- `LEN`=1: single bit in cycle k+1, FIN in k+2.
- All outputs come straight from flops; no combinational path from any input to any output.

## Test plan
- Reset: hold `RESET`=1 with `START`=1, `LEN`=3 for 2 cycles → `E`,`VALID`,`BUSY`,`DONE` all 0; after release, first accepted START yields first bit one cycle later.
- Basic send, `WIDTH`=8: `DATA`=8'b0000_0110, `LEN`=3, pulse `START` → `E`=1,1,0 in three consecutive cycles with `VALID`=1, then `DONE`=1 for one cycle; driving `mealy_fsm` with this `E` gives `Z`=1 during the third bit.
- Full width and length reject: `DATA`=8'hA5, `LEN`=8 → `E`=1,0,1,0,0,1,0,1 then `DONE`; `LEN`=0 and `LEN`=9 → no `VALID`, stays IDLE.
- Repeat: `DATA`=3'b110, `LEN`=3, `REPEAT`=1 → `E`=110110110… with no gap; change `DATA` to 0 mid-stream → pattern unchanged; drop `REPEAT` → current pattern completes, then `DONE`.
- Ignored inputs: pulse `START` with new `DATA` during SHIFT and during FIN → running pattern unaffected, no second transmission.
- Reset mid-operation: assert `RESET` on the 2nd bit of `LEN`=5 → next cycle all outputs 0, no `DONE`; subsequent START sends a full fresh pattern.
